// File: rtl/vedic_mult_pipe_if.sv
// ----------------------------------------------------------------
// vedic_mult_pipe_if: operand/result stream bundle for vedic_mult_pipe
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

interface vedic_mult_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 in_signed;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_p;
  logic [TAG_W-1:0]     out_tag;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_p, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_p, out_tag
  );
endinterface

`default_nettype wire

// File: rtl/vedic_mult_pipe.sv
// ----------------------------------------------------------------
// vedic_mult_pipe: pipelined recursive Urdhva-Tiryagbhyam multiplier
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module vedic_mult_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  vedic_mult_pipe_if.slave bus
);
  localparam int LAT = $clog2(WIDTH);

  logic               advance;
  logic [LAT:1]       vld_q;
  logic [LAT-1:1]     neg_q;
  logic [TAG_W-1:0]   tag_q [1:LAT];
  logic [WIDTH-1:0]   mag_a_d, mag_b_d, mag_a_q, mag_b_q;
  logic               neg_d;

  assign advance       = !vld_q[LAT] || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_q[LAT];
  assign bus.out_tag   = tag_q[LAT];

  // The most negative operand maps to 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    mag_a_d = bus.in_a;
    mag_b_d = bus.in_b;
    if (bus.in_signed && bus.in_a[WIDTH-1]) mag_a_d = -bus.in_a;
    if (bus.in_signed && bus.in_b[WIDTH-1]) mag_b_d = -bus.in_b;
    neg_d = bus.in_signed && (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      neg_q   <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      for (int k = 1; k <= LAT; k++) tag_q[k] <= '0;
    end else if (advance) begin
      vld_q <= {vld_q[LAT-1:1], bus.in_valid};
      if (bus.in_valid) begin
        mag_a_q  <= mag_a_d;
        mag_b_q  <= mag_b_d;
        neg_q[1] <= neg_d;
        tag_q[1] <= bus.in_tag;
      end
      for (int k = 2; k <= LAT; k++)
        if (vld_q[k-1]) tag_q[k] <= tag_q[k-1];
      for (int k = 2; k <= LAT - 1; k++)
        if (vld_q[k-1]) neg_q[k] <= neg_q[k-1];
    end
  end

  // Level e holds all (WIDTH/2^e)^2 sub-products of 2^e-bit operand chunks,
  // packed as index (i*N + j) for a-chunk i and b-chunk j.
  for (genvar e = 1; e <= LAT; e++) begin : g_lvl
    localparam int S   = 1 << e;
    localparam int N   = WIDTH / S;
    localparam int PW  = 2 * S;
    localparam int TOT = N * N * PW;

    logic [TOT-1:0] pp_d;
    logic [TOT-1:0] pp_out;

    if (e == 1) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_i
        for (genvar j = 0; j < N; j++) begin : g_j
          logic a0, a1, b0, b1, t1, t2, c1, hh;
          assign a0 = mag_a_q[2*i];
          assign a1 = mag_a_q[2*i+1];
          assign b0 = mag_b_q[2*j];
          assign b1 = mag_b_q[2*j+1];
          assign t1 = a1 & b0;
          assign t2 = a0 & b1;
          assign c1 = t1 & t2;
          assign hh = a1 & b1;
          assign pp_d[(i*N+j)*PW +: PW] = {hh & c1, hh ^ c1, t1 ^ t2, a0 & b0};
        end
      end
      assign pp_out = pp_d;
    end else begin : g_comb
      localparam int NP = 2 * N;
      for (genvar i = 0; i < N; i++) begin : g_i
        for (genvar j = 0; j < N; j++) begin : g_j
          logic [S-1:0] hh, hl, lh, ll;
          assign hh = g_lvl[e-1].pp_out[((2*i+1)*NP + 2*j+1)*S +: S];
          assign hl = g_lvl[e-1].pp_out[((2*i+1)*NP + 2*j  )*S +: S];
          assign lh = g_lvl[e-1].pp_out[((2*i  )*NP + 2*j+1)*S +: S];
          assign ll = g_lvl[e-1].pp_out[((2*i  )*NP + 2*j  )*S +: S];
          assign pp_d[(i*N+j)*PW +: PW] =
              {hh, ll} + ((PW'(hl) + PW'(lh)) << (S/2));
        end
      end

      logic [TOT-1:0] pp_q;
      if (e < LAT) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)                      pp_q <= '0;
          else if (advance && vld_q[e-1])  pp_q <= pp_d;
        end
      end else begin : g_fin
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)                      pp_q <= '0;
          else if (advance && vld_q[e-1])  pp_q <= neg_q[e-1] ? -pp_d : pp_d;
        end
      end
      assign pp_out = pp_q;
    end
  end

  assign bus.out_p = g_lvl[LAT].pp_out;
endmodule

`default_nettype wire

// File: tb/tb_vedic_mult_pipe.sv
// ----------------------------------------------------------------
// tb_vedic_mult_pipe: vector table plus scoreboard bench for vedic_mult_pipe
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module tb_vedic_mult_pipe;
  localparam int W   = 16;
  localparam int TW  = 4;
  localparam int LAT = $clog2(W);

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           s;
    logic [TW-1:0]  t;
    logic [2*W-1:0] p;
  } vec_t;

  typedef struct {
    logic [2*W-1:0] p;
    logic [TW-1:0]  t;
    int             acc;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  vedic_mult_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();
  vedic_mult_pipe #(.WIDTH(W), .TAG_W(TW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  sb_t  sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic lat_chk = 1'b0;

  task automatic check(input string name, input logic ok, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    longint x, y;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    return (2*W)'(x * y);
  endfunction

  // Called at a falling edge; covers the transfer happening on the next rising edge.
  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic [TW-1:0] t, input logic [2*W-1:0] exp,
                       input logic ordy, output logic acc);
    sb_t h;
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_signed = s;
    bus.in_tag    = t;
    bus.out_ready = ordy;
    #1;
    if (sb.size() == 0) begin
      check("no_spurious", bus.out_valid == 1'b0, 64'(bus.out_valid), 64'd0);
    end else if (bus.out_valid) begin
      h = sb[0];
      if (ordy) begin
        void'(sb.pop_front());
        check("result", {bus.out_p, bus.out_tag} == {h.p, h.t},
              64'({bus.out_p, bus.out_tag}), 64'({h.p, h.t}));
        if (lat_chk)
          check("latency", (ecnt - h.acc + 1) == LAT, 64'(ecnt - h.acc + 1), 64'(LAT));
      end else begin
        check("stall_ready", bus.in_ready == 1'b0, 64'(bus.in_ready), 64'd0);
        check("stall_hold", {bus.out_p, bus.out_tag} == {h.p, h.t},
              64'({bus.out_p, bus.out_tag}), 64'({h.p, h.t}));
      end
    end
    acc = v && bus.in_ready;
    if (acc) sb.push_back('{p: exp, t: t, acc: ecnt + 1});
    @(negedge clk);
  endtask

  task automatic drain();
    logic acc;
    for (int k = 0; k < 40 && sb.size() != 0; k++)
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, acc);
    check("drain", sb.size() == 0, 64'(sb.size()), 64'd0);
  endtask

  vec_t vt[12];
  initial begin
    logic acc;
    int   sent, nacc, cyc;
    logic [W-1:0] ra, rb;
    logic rs;
    logic [TW-1:0] rt;

    vt[0]  = '{a: 16'hFFFF, b: 16'hFFFF, s: 1'b0, t: 4'h2, p: 32'hFFFE0001};
    vt[1]  = '{a: 16'hFFFF, b: 16'hFFFF, s: 1'b1, t: 4'h3, p: 32'h00000001};
    vt[2]  = '{a: 16'h8000, b: 16'h8000, s: 1'b1, t: 4'h4, p: 32'h40000000};
    vt[3]  = '{a: 16'hFFFF, b: 16'h0002, s: 1'b0, t: 4'h5, p: 32'h0001FFFE};
    vt[4]  = '{a: 16'h8000, b: 16'h0001, s: 1'b1, t: 4'h6, p: 32'hFFFF8000};
    vt[5]  = '{a: 16'h0007, b: 16'hFFFD, s: 1'b1, t: 4'h7, p: 32'hFFFFFFEB};
    vt[6]  = '{a: 16'h8000, b: 16'h8000, s: 1'b0, t: 4'h8, p: 32'h40000000};
    vt[7]  = '{a: 16'h8000, b: 16'hFFFF, s: 1'b0, t: 4'h9, p: 32'h7FFF8000};
    vt[8]  = '{a: 16'h7FFF, b: 16'h8000, s: 1'b1, t: 4'hA, p: 32'hC0008000};
    vt[9]  = '{a: 16'h0000, b: 16'hFFFF, s: 1'b1, t: 4'hB, p: 32'h00000000};
    vt[10] = '{a: 16'h1234, b: 16'h5678, s: 1'b0, t: 4'hC, p: 32'h06260060};
    vt[11] = '{a: 16'hFFFE, b: 16'h0003, s: 1'b1, t: 4'hD, p: 32'hFFFFFFFA};

    // Reset held with a valid beat offered.
    rst_n = 1'b0;
    bus.in_valid = 1'b1; bus.in_a = 16'd3; bus.in_b = 16'd5;
    bus.in_signed = 1'b0; bus.in_tag = 4'h1; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", bus.out_valid == 1'b0, 64'(bus.out_valid), 64'd0);
    check("rst_out_p", bus.out_p == '0, 64'(bus.out_p), 64'd0);
    check("rst_out_tag", bus.out_tag == '0, 64'(bus.out_tag), 64'd0);
    check("rst_in_ready", bus.in_ready == 1'b1, 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    lat_chk = 1'b1;
    drive(1'b1, 16'd3, 16'd5, 1'b0, 4'h1, 32'd15, 1'b1, acc);
    drain();

    for (int i = 0; i < 12; i++)
      drive(1'b1, vt[i].a, vt[i].b, vt[i].s, vt[i].t, vt[i].p, 1'b1, acc);
    drain();

    for (int n = 0; n < 16; n++)
      drive(1'b1, W'(n), W'(n), 1'b0, TW'(n), (2*W)'(n * n), 1'b1, acc);
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 4'hE, 32'hFFFE0001, 1'b1, acc);
    drain();

    // Eight beats with a three-cycle downstream stall in the middle.
    lat_chk = 1'b0;
    sent = 0;
    for (int k = 0; k < 40 && sent < 8; k++) begin
      drive(1'b1, W'(100 + sent), W'(sent + 1), sent[0], TW'(sent + 8),
            (2*W)'((100 + sent) * (sent + 1)), !(k >= 5 && k < 8), acc);
      if (acc) sent++;
    end
    check("bp_sent", sent == 8, 64'(sent), 64'd8);
    drain();

    // Reset while stalled with three beats in flight.
    for (int k = 0; k < 3; k++)
      drive(1'b1, W'(k + 20), 16'd3, 1'b0, TW'(k), (2*W)'((k + 20) * 3), 1'b0, acc);
    repeat (2) drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, acc);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", bus.out_valid == 1'b0, 64'(bus.out_valid), 64'd0);
    check("midrst_p", bus.out_p == '0, 64'(bus.out_p), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst_ready", bus.in_ready == 1'b1, 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    repeat (6) drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, acc);
    lat_chk = 1'b1;
    drive(1'b1, 16'd9, 16'hFFF7, 1'b1, 4'h9, 32'hFFFFFFAF, 1'b1, acc);
    drain();

    // Random traffic with random bubbles and backpressure.
    lat_chk = 1'b0;
    nacc = 0;
    cyc  = 0;
    while (nacc < 10000 && cyc < 60000) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      rt = TW'($urandom);
      drive($urandom_range(0, 3) != 0, ra, rb, rs, rt, model(ra, rb, rs),
            $urandom_range(0, 3) != 0, acc);
      if (acc) nacc++;
      cyc++;
    end
    check("random_beats", nacc == 10000, 64'(nacc), 64'd10000);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

`default_nettype wire
